// File: rtl/d_hazard_ctrl_if.sv
// rtl/d_hazard_ctrl_if.sv - D-stage hazard controller bundle: decoded D fields in, stall/forward selects out
interface d_hazard_ctrl_if;
   logic [4:0] D_rs_addr;
   logic [4:0] D_rt_addr;
   logic [1:0] D_Tuse_rs;
   logic [1:0] D_Tuse_rt;
   logic [4:0] D_A3;
   logic [1:0] D_Tnew;
   logic [1:0] D_md_op;
   logic       D_md_use;
   logic       stall;
   logic       E_clr;
   logic [2:0] s_D_rs_data;
   logic [2:0] s_D_rt_data;
   logic       md_busy;

   modport master (
      output D_rs_addr, D_rt_addr, D_Tuse_rs, D_Tuse_rt, D_A3, D_Tnew, D_md_op, D_md_use,
      input  stall, E_clr, s_D_rs_data, s_D_rt_data, md_busy
   );

   modport slave (
      input  D_rs_addr, D_rt_addr, D_Tuse_rs, D_Tuse_rt, D_A3, D_Tnew, D_md_op, D_md_use,
      output stall, E_clr, s_D_rs_data, s_D_rt_data, md_busy
   );
endinterface

// File: rtl/d_hazard_ctrl.sv
// rtl/d_hazard_ctrl.sv - D-stage hazard/forwarding control with E/M/W shadow scoreboard and mult/div busy counter
module d_hazard_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input logic            clk,
   input logic            reset,
   d_hazard_ctrl_if.slave hz
);
   localparam logic [2:0] SEL_O   = 3'b000;
   localparam logic [2:0] SEL_E   = 3'b001;
   localparam logic [2:0] SEL_M   = 3'b010;
   localparam logic [2:0] SEL_W   = 3'b011;
   localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
   localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

   logic [4:0] e_a3_q, e_a3_d, m_a3_q, m_a3_d, w_a3_q, w_a3_d;
   logic [1:0] e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d, w_tnew_q, w_tnew_d;
   logic [1:0] e_md_op_q, e_md_op_d;
   logic [3:0] cnt_q, cnt_d;
   logic       stall_rs, stall_rt, md_busy, stall;
   logic [2:0] sel_rs, sel_rt;

   // Returns {stall, select}; only the youngest matching producer is considered.
   function automatic logic [3:0] fwd_one(
      input logic [4:0] addr,
      input logic [1:0] tuse,
      input logic [4:0] e_a3,
      input logic [1:0] e_tnew,
      input logic [4:0] m_a3,
      input logic [1:0] m_tnew,
      input logic [4:0] w_a3,
      input logic [1:0] w_tnew
   );
      logic       hit;
      logic [1:0] tnew;
      logic [2:0] sel;
      hit  = 1'b1;
      tnew = 2'd0;
      sel  = SEL_O;
      if (tuse == 2'd3 || addr == 5'd0) begin
         hit = 1'b0;
      end else if (e_a3 == addr) begin
         tnew = e_tnew;
         sel  = SEL_E;
      end else if (m_a3 == addr) begin
         tnew = m_tnew;
         sel  = SEL_M;
      end else if (w_a3 == addr) begin
         tnew = w_tnew;
         sel  = SEL_W;
      end else begin
         hit = 1'b0;
      end
      if (!hit)              fwd_one = {1'b0, SEL_O};
      else if (tnew == 2'd0) fwd_one = {1'b0, sel};
      else if (tnew > tuse)  fwd_one = {1'b1, SEL_O};
      else                   fwd_one = {1'b0, SEL_O};
   endfunction

   function automatic logic [1:0] dec_sat(input logic [1:0] v);
      dec_sat = (v == 2'd0) ? 2'd0 : v - 2'd1;
   endfunction

   always_comb begin
      {stall_rs, sel_rs} = fwd_one(hz.D_rs_addr, hz.D_Tuse_rs, e_a3_q, e_tnew_q,
                                   m_a3_q, m_tnew_q, w_a3_q, w_tnew_q);
      {stall_rt, sel_rt} = fwd_one(hz.D_rt_addr, hz.D_Tuse_rt, e_a3_q, e_tnew_q,
                                   m_a3_q, m_tnew_q, w_a3_q, w_tnew_q);
      md_busy = (e_md_op_q == 2'b01) || (e_md_op_q == 2'b10) || (cnt_q != 4'd0);
      stall   = stall_rs | stall_rt | (hz.D_md_use & md_busy);

      if (stall) begin
         e_a3_d    = 5'd0;
         e_tnew_d  = 2'd0;
         e_md_op_d = 2'b00;
      end else begin
         e_a3_d    = hz.D_A3;
         e_tnew_d  = hz.D_Tnew;
         e_md_op_d = hz.D_md_op;
      end
      m_a3_d   = e_a3_q;
      m_tnew_d = dec_sat(e_tnew_q);
      w_a3_d   = m_a3_q;
      w_tnew_d = dec_sat(m_tnew_q);

      // The counter starts as the op leaves E, so busy covers E plus CYC more cycles.
      if (e_md_op_q == 2'b01)      cnt_d = MULT_LD;
      else if (e_md_op_q == 2'b10) cnt_d = DIV_LD;
      else if (cnt_q != 4'd0)      cnt_d = cnt_q - 4'd1;
      else                         cnt_d = cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_a3_q    <= 5'd0;
         e_tnew_q  <= 2'd0;
         e_md_op_q <= 2'b00;
         m_a3_q    <= 5'd0;
         m_tnew_q  <= 2'd0;
         w_a3_q    <= 5'd0;
         w_tnew_q  <= 2'd0;
         cnt_q     <= 4'd0;
      end else begin
         e_a3_q    <= e_a3_d;
         e_tnew_q  <= e_tnew_d;
         e_md_op_q <= e_md_op_d;
         m_a3_q    <= m_a3_d;
         m_tnew_q  <= m_tnew_d;
         w_a3_q    <= w_a3_d;
         w_tnew_q  <= w_tnew_d;
         cnt_q     <= cnt_d;
      end
   end

   assign hz.stall       = stall;
   assign hz.E_clr       = stall;
   assign hz.s_D_rs_data = sel_rs;
   assign hz.s_D_rt_data = sel_rt;
   assign hz.md_busy     = md_busy;
endmodule
